// File: rtl/reg_alu_core.sv
// Multi-cycle register-file core: load/mov/add/sub over a shared bus, valid/ready instruction intake.
// Define ALU_EXT_EN to add and/xor/shl. Without it those opcodes retire as nop.
module reg_alu_core #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    parameter int REG_AW = 4,
    parameter int OPC_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              done,
    output logic              busy,
    output logic [DATA_W-1:0] bus_out,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_IMM,
        MOV,
        T1,
        T2,
        T3,
        NOP
    } state_t;

    localparam logic [OPC_W-1:0] OP_LOAD = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_MOV  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(6);

    state_t state, state_next;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] a_reg, g_reg;
    logic [OPC_W-1:0]  op_q;
    logic [REG_AW-1:0] rx_q, ry_q;

    logic [OPC_W-1:0]  op_in;
    logic [REG_AW-1:0] rx_in, ry_in;
    logic              xfer;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              retire;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              op_in_is_alu;

    assign op_in = instr[OPC_W+2*REG_AW-1 -: OPC_W];
    assign rx_in = instr[2*REG_AW-1 -: REG_AW];
    assign ry_in = instr[REG_AW-1:0];
    assign xfer  = instr_valid && instr_ready;

    assign instr_ready = (state == IDLE) || (state == LOAD_IMM);
    assign busy        = (state != IDLE);
    assign dbg_data    = regs[dbg_addr];
    assign alu_b       = regs[ry_q];

    // Opcodes outside the built ALU fall through to the NOP path.
    always_comb begin
        op_in_is_alu = 1'b0;
        case (op_in)
            OP_ADD, OP_SUB: op_in_is_alu = 1'b1;
`ifdef ALU_EXT_EN
            OP_AND, OP_XOR, OP_SHL: op_in_is_alu = 1'b1;
`endif
            default: op_in_is_alu = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (op_in == OP_LOAD)
                        state_next = LOAD_IMM;
                    else if (op_in == OP_MOV)
                        state_next = MOV;
                    else if (op_in_is_alu)
                        state_next = T1;
                    else
                        state_next = NOP;
                end
            end
            LOAD_IMM: begin
                if (xfer)
                    state_next = IDLE;
            end
            T1:      state_next = T2;
            T2:      state_next = T3;
            MOV:     state_next = IDLE;
            T3:      state_next = IDLE;
            NOP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        alu_result = a_reg + alu_b;
        case (op_q)
            OP_ADD:  alu_result = a_reg + alu_b;
            OP_SUB:  alu_result = a_reg - alu_b;
`ifdef ALU_EXT_EN
            OP_AND:  alu_result = a_reg & alu_b;
            OP_XOR:  alu_result = a_reg ^ alu_b;
            OP_SHL:  alu_result = alu_b << 1;
`endif
            default: alu_result = a_reg + alu_b;
        endcase
    end

    always_comb begin
        bus_out = '0;
        case (state)
            LOAD_IMM: bus_out = instr;
            MOV:      bus_out = regs[ry_q];
            T1:       bus_out = regs[rx_q];
            T2:       bus_out = regs[ry_q];
            T3:       bus_out = g_reg;
            default:  bus_out = '0;
        endcase
    end

    // Single register write port; every write coincides with retirement.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        retire  = 1'b0;
        case (state)
            LOAD_IMM: begin
                if (xfer) begin
                    wr_en   = 1'b1;
                    wr_data = instr;
                    retire  = 1'b1;
                end
            end
            MOV: begin
                wr_en   = 1'b1;
                wr_data = regs[ry_q];
                retire  = 1'b1;
            end
            T3: begin
                wr_en   = 1'b1;
                wr_data = g_reg;
                retire  = 1'b1;
            end
            NOP:     retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= '0;
            rx_q  <= '0;
            ry_q  <= '0;
            a_reg <= '0;
            g_reg <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= retire;
            if (state == IDLE && xfer) begin
                op_q <= op_in;
                rx_q <= rx_in;
                ry_q <= ry_in;
            end
            if (state == T1)
                a_reg <= regs[rx_q];
            if (state == T2)
                g_reg <= alu_result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[rx_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_reg_alu_core.sv
// Directed bench for reg_alu_core: an instruction-level model predicts registers, done, busy,
// ready and bus_out every cycle; literal checks pin key register values.
`timescale 1ns/100ps
module tb_reg_alu_core;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        done;
    logic        busy;
    logic [15:0] bus_out;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

`ifdef ALU_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic [15:0] m_r [16];
    bit          loadwait   = 0;
    bit          pend_valid = 0;
    bit          pend_write = 0;
    int          pend_cycle = 0;
    int          pend_start = 0;
    logic [3:0]  pend_addr  = '0;
    logic [15:0] pend_data  = '0;
    logic [15:0] pend_bus [3];

    reg_alu_core dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .done       (done),
        .busy       (busy),
        .bus_out    (bus_out),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit modelIsAlu(input logic [2:0] op);
        if (op == 3'd2 || op == 3'd3)
            return 1'b1;
        if (EXT && (op == 3'd4 || op == 3'd5 || op == 3'd6))
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] modelAlu(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
        case (op)
            3'd2:    return 16'((32'(x) + 32'(y)) % 65536);
            3'd3:    return 16'((32'(x) + 65536 - 32'(y)) % 65536);
            3'd4:    return x & y;
            3'd5:    return x ^ y;
            3'd6:    return 16'((32'(y) * 2) % 65536);
            default: return 16'h0;
        endcase
    endfunction

    task automatic checkSig(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Per-cycle comparison against the instruction-level model.
    always @(negedge clk) begin
        logic        busy_e, done_e, ready_e;
        logic [15:0] bus_e;
        logic [3:0]  sweep;
        cyc++;
        sweep = 4'(cyc % 16);
        dbg_addr = sweep;
        if (pend_valid && cyc == pend_cycle && pend_write)
            m_r[pend_addr] = pend_data;
        #1;
        busy_e  = loadwait || (pend_valid && cyc < pend_cycle);
        done_e  = pend_valid && cyc == pend_cycle;
        ready_e = !busy_e || loadwait;
        if (loadwait)
            bus_e = instr;
        else if (busy_e)
            bus_e = pend_bus[cyc - pend_start];
        else
            bus_e = 16'h0;
        checkSig("done", {15'h0, done}, {15'h0, done_e});
        checkSig("busy", {15'h0, busy}, {15'h0, busy_e});
        checkSig("instr_ready", {15'h0, instr_ready}, {15'h0, ready_e});
        checkSig("bus_out", bus_out, bus_e);
        checkSig($sformatf("R%0d", sweep), dbg_data, m_r[sweep]);
        if (pend_valid && cyc >= pend_cycle)
            pend_valid = 0;
    end

    task automatic sendWord(input logic [15:0] w, output logic ok);
        logic r;
        ok = 1'b0;
        instr = w;
        instr_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            r = instr_ready;
            @(posedge clk);
            if (r)
                ok = 1'b1;
        end
        #1;
        instr_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL accept: got no transfer want transfer of %h", w);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] rx, input logic [3:0] ry,
                                 input logic [15:0] imm, input int gap);
        logic ok;
        int   n;
        sendWord({6'b101101, op, rx, ry}, ok);
        if (!ok)
            return;
        n = cyc;
        pend_bus[0] = 16'h0;
        pend_bus[1] = 16'h0;
        pend_bus[2] = 16'h0;
        if (op == 3'd0) begin
            loadwait = 1;
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            sendWord(imm, ok);
            loadwait = 0;
            if (!ok)
                return;
            pend_write = 1;
            pend_addr  = rx;
            pend_data  = imm;
            pend_cycle = cyc + 1;
            pend_start = cyc + 1;
        end else if (op == 3'd1) begin
            pend_write  = 1;
            pend_addr   = rx;
            pend_data   = m_r[ry];
            pend_bus[0] = m_r[ry];
            pend_cycle  = n + 2;
            pend_start  = n + 1;
        end else if (modelIsAlu(op)) begin
            pend_write  = 1;
            pend_addr   = rx;
            pend_data   = modelAlu(op, m_r[rx], m_r[ry]);
            pend_bus[0] = m_r[rx];
            pend_bus[1] = m_r[ry];
            pend_bus[2] = pend_data;
            pend_cycle  = n + 4;
            pend_start  = n + 1;
        end else begin
            pend_write = 0;
            pend_cycle = n + 2;
            pend_start = n + 1;
        end
        pend_valid = 1;
    endtask

    task automatic waitIdle();
        for (int t = 0; t < 20 && (pend_valid || loadwait); t++)
            @(posedge clk);
        if (pend_valid || loadwait) begin
            total++;
            bad++;
            $display("[TB] FAIL retire: got still pending want retired");
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] addr, input logic [15:0] want);
        @(posedge clk);
        #2;
        dbg_addr = addr;
        #1;
        checkSig(name, dbg_data, want);
    endtask

    task automatic doReset();
        reset = 1'b1;
        instr_valid = 1'b0;
        pend_valid = 0;
        loadwait = 0;
        for (int i = 0; i < 16; i++)
            m_r[i] = 16'h0;
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++)
            m_r[i] = 16'h0;
        instr = 16'h0;
        instr_valid = 1'b0;
        dbg_addr = 4'h0;
        reset = 1'b1;
        #10;
        reset = 1'b0;
        @(posedge clk);
        #2;
        checkSig("reset_done", {15'h0, done}, 16'h0);
        checkSig("reset_busy", {15'h0, busy}, 16'h0);
        checkSig("reset_ready", {15'h0, instr_ready}, 16'h1);
        checkSig("reset_bus", bus_out, 16'h0);
        for (int i = 0; i < 16; i++)
            checkOutput("reset_reg", 4'(i), 16'h0);

        // loads
        applyStimulus(3'd0, 4'd1, 4'd0, 16'h0007, 0);
        applyStimulus(3'd0, 4'd2, 4'd0, 16'h0008, 0);
        waitIdle();
        checkOutput("load_r1", 4'd1, 16'h0007);
        checkOutput("load_r2", 4'd2, 16'h0008);

        // mov / add / sub with wrap
        applyStimulus(3'd1, 4'd3, 4'd2, 16'h0, 0);
        applyStimulus(3'd2, 4'd3, 4'd1, 16'h0, 0);
        applyStimulus(3'd3, 4'd1, 4'd2, 16'h0, 0);
        applyStimulus(3'd1, 4'd4, 4'd1, 16'h0, 0);
        waitIdle();
        checkOutput("add_r3", 4'd3, 16'h000F);
        checkOutput("sub_r1", 4'd1, 16'hFFFF);
        checkOutput("mov_r4", 4'd4, 16'hFFFF);

        // load waits for a late immediate
        applyStimulus(3'd0, 4'd5, 4'd0, 16'h1234, 6);
        waitIdle();
        checkOutput("late_imm_r5", 4'd5, 16'h1234);

        // rx==ry cases
        applyStimulus(3'd3, 4'd4, 4'd4, 16'h0, 0);
        applyStimulus(3'd2, 4'd5, 4'd5, 16'h0, 0);
        waitIdle();
        checkOutput("sub_self_r4", 4'd4, 16'h0000);
        checkOutput("add_self_r5", 4'd5, 16'h2468);

        // reset in T2 of add r2,r2
        applyStimulus(3'd2, 4'd2, 4'd2, 16'h0, 0);
        @(posedge clk);
        #1;
        doReset();
        checkOutput("abort_r2", 4'd2, 16'h0000);
        applyStimulus(3'd0, 4'd6, 4'd0, 16'h0055, 0);
        waitIdle();
        checkOutput("after_reset_r6", 4'd6, 16'h0055);

        // xor r1,r1 and the other extension opcodes
        applyStimulus(3'd0, 4'd1, 4'd0, 16'h0005, 0);
        applyStimulus(3'd5, 4'd1, 4'd1, 16'h0, 0);
        waitIdle();
        checkOutput("xor_r1", 4'd1, EXT ? 16'h0000 : 16'h0005);
        applyStimulus(3'd0, 4'd7, 4'd0, 16'h00F0, 0);
        applyStimulus(3'd4, 4'd7, 4'd6, 16'h0, 0);
        applyStimulus(3'd6, 4'd8, 4'd6, 16'h0, 0);
        applyStimulus(3'd7, 4'd6, 4'd7, 16'h0, 0);
        applyStimulus(3'd0, 4'd0, 4'd0, 16'h8001, 0);
        applyStimulus(3'd6, 4'd9, 4'd0, 16'h0, 0);
        waitIdle();
        checkOutput("and_r7", 4'd7, EXT ? 16'h0050 : 16'h00F0);
        checkOutput("shl_r8", 4'd8, EXT ? 16'h00AA : 16'h0000);
        checkOutput("nop_r6", 4'd6, 16'h0055);
        checkOutput("shl_wrap_r9", 4'd9, EXT ? 16'h0002 : 16'h0000);

        repeat (20) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
